// File: rtl/bidir_shift_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module : shift_engine_pkg
// Brief  : Shared types and constants for the bidir_shift_engine block.
// Rev    : 1.0
// ============================================================================
package shift_engine_pkg;

    typedef enum logic [1:0] {
        LOGICAL = 2'b00,
        ROTATE  = 2'b01,
        ARITH   = 2'b10,
        FILL    = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bidir_shift_engine_if.sv
`default_nettype none
// ============================================================================
// Module : bidir_shift_engine_if
// Brief  : Request/result valid-ready streams of the shift engine.
// Rev    : 1.0
// ============================================================================
interface bidir_shift_engine_if #(
    parameter int WIDTH = 8
) ();
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_count;
    logic             in_dir;
    logic [1:0]       in_mode;
    logic             in_fill;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;

    modport slave (
        input  in_valid, in_data, in_count, in_dir, in_mode, in_fill, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );

    modport master (
        output in_valid, in_data, in_count, in_dir, in_mode, in_fill, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );
endinterface
`default_nettype wire

// File: rtl/bidir_shift_engine_step.sv
`default_nettype none
// ============================================================================
// Module : shift_step_unit
// Brief  : Combinational single step shift/rotate by k (1..STEP) with carry.
//          Sign fill for ARITH right shifts only when SHIFT_ENGINE_ARITH_EN.
// Rev    : 1.0
// ============================================================================
module shift_step_unit
    import shift_engine_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [CNT_W-1:0] i_k,
    input  logic             i_dir,
    input  shift_mode_t      i_mode,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_value,
    output logic             o_carry
);
    localparam logic [CNT_W-1:0] c_WIDTH = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] c_ONES  = '1;

    logic [CNT_W-1:0] w_back;
    logic [WIDTH-1:0] w_main;
    logic [WIDTH-1:0] w_wrap;
    logic [WIDTH-1:0] w_vac;
    logic [WIDTH-1:0] w_pick;
    logic [WIDTH-1:0] w_fillpat;

    assign w_back = c_WIDTH - i_k;

    // w_wrap holds the bits leaving one end, aligned to the vacated end.
    always_comb begin
        if (i_dir == DIR_RIGHT) begin
            w_main = i_value >> i_k;
            w_wrap = i_value << w_back;
            w_vac  = ~(c_ONES >> i_k);
            w_pick = i_value >> (i_k - c_ONE);
        end else begin
            w_main = i_value << i_k;
            w_wrap = i_value >> w_back;
            w_vac  = ~(c_ONES << i_k);
            w_pick = i_value >> w_back;
        end
    end

    always_comb begin
        w_fillpat = '0;
        case (i_mode)
            ROTATE:  w_fillpat = w_wrap;
            FILL:    w_fillpat = {WIDTH{i_fill}};
`ifdef SHIFT_ENGINE_ARITH_EN
            ARITH:   w_fillpat = {WIDTH{(i_dir == DIR_RIGHT) & i_value[WIDTH-1]}};
`else
            ARITH:   w_fillpat = '0;
`endif
            default: w_fillpat = '0;
        endcase
    end

    assign o_value = w_main | (w_vac & w_fillpat);
    assign o_carry = w_pick[0];

endmodule
`default_nettype wire

// File: rtl/bidir_shift_engine.sv
`default_nettype none
// ============================================================================
// Module : bidir_shift_engine
// Brief  : Handshaked multi-cycle shift/rotate engine, up to STEP bits/clock.
//          Optional macro SHIFT_ENGINE_ARITH_EN enables arithmetic right shift.
// Rev    : 1.0
// ============================================================================
module bidir_shift_engine
    import shift_engine_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bidir_shift_engine_if.slave  bus
);
    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_WIDTH = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_STEP  = CNT_W'(STEP);

    shift_state_t     r_state;
    shift_state_t     w_state_nx;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_rem;
    logic             r_dir;
    shift_mode_t      r_mode;
    logic             r_fill;
    logic             r_carry;

    logic [CNT_W-1:0] w_count_clamped;
    logic [CNT_W-1:0] w_k;
    logic [WIDTH-1:0] w_step_value;
    logic             w_step_carry;
    logic             w_accept;
    logic             w_ready;
    logic             w_valid;

    // Counts beyond WIDTH saturate; they are never wrapped modulo WIDTH.
    assign w_count_clamped = (bus.in_count > c_WIDTH) ? c_WIDTH : bus.in_count;
    assign w_k             = (r_rem > c_STEP) ? c_STEP : r_rem;

    shift_step_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .i_value (r_data),
        .i_k     (w_k),
        .i_dir   (r_dir),
        .i_mode  (r_mode),
        .i_fill  (r_fill),
        .o_value (w_step_value),
        .o_carry (w_step_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ready    = 1'b0;
        w_valid    = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = (w_count_clamped == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (r_rem == w_k) begin
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                w_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_rem   <= '0;
            r_dir   <= DIR_LEFT;
            r_mode  <= LOGICAL;
            r_fill  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_data  <= bus.in_data;
            r_rem   <= w_count_clamped;
            r_dir   <= bus.in_dir;
            r_mode  <= shift_mode_t'(bus.in_mode);
            r_fill  <= bus.in_fill;
            r_carry <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_data  <= w_step_value;
            r_carry <= w_step_carry;
            r_rem   <= r_rem - w_k;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = r_data;
    assign bus.out_carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_bidir_shift_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_bidir_shift_engine
// Brief  : Self-checking bench; WIDTH=8 engines with STEP=1 (a) and STEP=4 (b).
// Rev    : 1.0
// ============================================================================
module tb_bidir_shift_engine;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
`ifdef SHIFT_ENGINE_ARITH_EN
    localparam bit c_ARITH = 1'b1;
`else
    localparam bit c_ARITH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bidir_shift_engine_if #(.WIDTH(W)) ifa ();
    bidir_shift_engine_if #(.WIDTH(W)) ifb ();

    bidir_shift_engine #(.WIDTH(W), .STEP(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    bidir_shift_engine #(.WIDTH(W), .STEP(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: each result bit is looked up in the original word at distance n.
    function automatic void model(input logic [W-1:0] d, input int cnt, input logic dir,
                                  input logic [1:0] mode, input logic f,
                                  output logic [W-1:0] r, output logic c);
        int n;
        int src;
        n = (cnt > W) ? W : cnt;
        r = '0;
        for (int i = 0; i < W; i++) begin
            src = dir ? i + n : i - n;
            if (src >= 0 && src < W)  r[i] = d[src];
            else if (mode == 2'b01)   r[i] = d[(src + W) % W];
            else if (mode == 2'b11)   r[i] = f;
            else if (mode == 2'b10)   r[i] = (c_ARITH && dir) ? d[W-1] : 1'b0;
            else                      r[i] = 1'b0;
        end
        if (n == 0)   c = 1'b0;
        else if (dir) c = d[n-1];
        else          c = d[W-n];
    endfunction

    task automatic drive(input int sel, input logic v, input logic [W-1:0] d,
                         input logic [CW-1:0] c, input logic dir, input logic [1:0] m,
                         input logic f);
        if (sel == 0) begin
            ifa.in_valid = v; ifa.in_data = d; ifa.in_count = c;
            ifa.in_dir = dir; ifa.in_mode = m; ifa.in_fill = f;
        end else begin
            ifb.in_valid = v; ifb.in_data = d; ifb.in_count = c;
            ifb.in_dir = dir; ifb.in_mode = m; ifb.in_fill = f;
        end
    endtask

    task automatic set_oready(input int sel, input logic r);
        if (sel == 0) ifa.out_ready = r;
        else          ifb.out_ready = r;
    endtask

    function automatic logic rd_ready(input int sel);
        return (sel == 0) ? ifa.in_ready : ifb.in_ready;
    endfunction
    function automatic logic rd_valid(input int sel);
        return (sel == 0) ? ifa.out_valid : ifb.out_valid;
    endfunction
    function automatic logic [W-1:0] rd_data(input int sel);
        return (sel == 0) ? ifa.out_data : ifb.out_data;
    endfunction
    function automatic logic rd_carry(input int sel);
        return (sel == 0) ? ifa.out_carry : ifb.out_carry;
    endfunction

    task automatic run_job(input int sel, input string tag, input logic [W-1:0] d,
                           input int cnt, input logic dir, input logic [1:0] mode,
                           input logic f, input int hold,
                           output logic [W-1:0] od, output logic oc);
        logic [W-1:0] xd;
        logic         xc;
        logic [CW-1:0] cbits;
        int step, n, exp_lat, lat, guard;
        step    = (sel == 0) ? 1 : 4;
        n       = (cnt > W) ? W : cnt;
        exp_lat = (n + step - 1) / step;
        cbits   = cnt[CW-1:0];
        model(d, cnt, dir, mode, f, xd, xc);
        guard = 0;
        while (!rd_ready(sel) && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        chk({tag, ":in_ready_idle"}, rd_ready(sel), 1);
        drive(sel, 1'b1, d, cbits, dir, mode, f);
        @(posedge clk); #1;
        drive(sel, 1'b0, d, cbits, dir, mode, f);
        lat = 0;
        while (!rd_valid(sel) && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, ":latency"}, lat, exp_lat);
        chk({tag, ":data"}, rd_data(sel), xd);
        chk({tag, ":carry"}, rd_carry(sel), xc);
        od = rd_data(sel);
        oc = rd_carry(sel);
        for (int h = 0; h < hold; h++) begin
            drive(sel, 1'b1, ~d, cbits, ~dir, mode, ~f);
            @(posedge clk); #1;
            chk({tag, ":hold_valid"}, rd_valid(sel), 1);
            chk({tag, ":hold_ready"}, rd_ready(sel), 0);
            chk({tag, ":hold_data"}, rd_data(sel), xd);
            chk({tag, ":hold_carry"}, rd_carry(sel), xc);
        end
        drive(sel, 1'b0, d, cbits, dir, mode, f);
        set_oready(sel, 1'b1);
        @(posedge clk); #1;
        set_oready(sel, 1'b0);
        chk({tag, ":valid_drop"}, rd_valid(sel), 0);
        chk({tag, ":ready_back"}, rd_ready(sel), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [W-1:0] od;
        logic         oc;
        int           vseen;
        drive(0, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        set_oready(0, 1'b0);
        set_oready(1, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset:in_ready", rd_ready(s), 1);
            chk("reset:out_valid", rd_valid(s), 0);
            chk("reset:out_data", rd_data(s), 0);
            chk("reset:out_carry", rd_carry(s), 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        run_job(0, "lsl3", 8'h96, 3, 1'b0, 2'b00, 1'b0, 0, od, oc);
        chk("lsl3:const_data", od, 8'hB0);
        chk("lsl3:const_carry", oc, 0);

        run_job(0, "ror3", 8'h96, 3, 1'b1, 2'b01, 1'b0, 0, od, oc);
        chk("ror3:const_data", od, 8'hD2);
        chk("ror3:const_carry", oc, 1);

        run_job(0, "asr2", 8'h96, 2, 1'b1, 2'b10, 1'b0, 0, od, oc);
        chk("asr2:const_data", od, c_ARITH ? 8'hE5 : 8'h25);
        chk("asr2:const_carry", oc, 1);

        run_job(1, "fill6", 8'h00, 6, 1'b0, 2'b11, 1'b1, 0, od, oc);
        chk("fill6:const_data", od, 8'h3F);
        chk("fill6:const_carry", oc, 0);

        run_job(0, "cnt0", 8'h5A, 0, 1'b0, 2'b00, 1'b0, 0, od, oc);
        chk("cnt0:const_data", od, 8'h5A);
        chk("cnt0:const_carry", oc, 0);

        run_job(0, "cnt12", 8'h97, 12, 1'b0, 2'b00, 1'b0, 0, od, oc);
        chk("cnt12:const_data", od, 8'h00);
        chk("cnt12:const_carry", oc, 1);

        run_job(0, "rol8", 8'hC3, 8, 1'b0, 2'b01, 1'b0, 0, od, oc);
        chk("rol8:const_data", od, 8'hC3);

        run_job(0, "hold5", 8'h96, 3, 1'b0, 2'b00, 1'b0, 5, od, oc);

        // Abort a job mid-SHIFT; the asynchronous reset must clear outputs at once.
        drive(0, 1'b1, 8'hFF, CW'(8), 1'b0, 2'b00, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'hFF, CW'(8), 1'b0, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid:out_valid", rd_valid(0), 0);
        chk("rst_mid:out_data", rd_data(0), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid:in_ready", rd_ready(0), 1);
        vseen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rd_valid(0)) vseen++;
        end
        chk("rst_mid:no_valid", vseen, 0);

        for (int i = 0; i < 80; i++) begin
            run_job(i % 2, (i % 2 == 0) ? "rand_a" : "rand_b",
                    W'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                    2'($urandom), 1'($urandom), int'($urandom_range(0, 2)), od, oc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
